// File: rtl/enigma_lcd_screen_builder.sv
// enigma_lcd_screen_builder: registered 2x16 LCD character source for status and keypress-history screens
module enigma_lcd_screen_builder #(
  parameter int NUM_ROTORS = 3,
  parameter int HIST_DEPTH = 32,
  parameter int HPTR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_or_hist,
  input  logic                    key_valid,
  input  logic [4:0]              befor,
  input  logic [4:0]              after,
  input  logic [5*NUM_ROTORS-1:0] shifts,
  input  logic [3*NUM_ROTORS-1:0] types,
  input  logic                    hist_clear,
  input  logic                    scroll_up,
  input  logic                    scroll_down,
  input  logic [4:0]              raddr,
  output logic [7:0]              dout,
  output logic [HPTR_W:0]         hist_count,
  output logic [HPTR_W:0]         scroll
);
  localparam logic [HPTR_W:0] DEPTH = (HPTR_W+1)'(HIST_DEPTH);
  localparam logic [HPTR_W:0] VIEW = (HPTR_W+1)'(16);
  logic [9:0] mem_q [HIST_DEPTH];
  logic [HPTR_W-1:0] wp_q, wp_d, idx;
  logic [HPTR_W:0] cnt_q, cnt_d, scr_q, scr_d, smax, age;
  logic [7:0] dout_q, dout_d, st_ch, hi_ch;
  logic [9:0] ent;
  logic wr, row;
  logic [3:0] col;
  function automatic logic [7:0] letter(input logic [4:0] v);
    return v > 5'd25 ? 8'h3F : 8'h41 + 8'(v);
  endfunction
  function automatic logic [7:0] digit(input logic [4:0] v, input logic hi);
    logic [4:0] t;
    t = v >= 5'd20 ? 5'd2 : v >= 5'd10 ? 5'd1 : 5'd0;
    return v > 5'd25 ? 8'h3F : 8'h30 + 8'(hi ? t : v - t * 5'd10);
  endfunction
  assign row = raddr[4];
  assign col = raddr[3:0];
  always_comb begin
    st_ch = 8'h20;
    if (col == 4'd0) st_ch = row ? 8'h54 : 8'h53;
    if (col == 4'd15) st_ch = letter(row ? after : befor);
    if (!row && col == 4'd13) st_ch = 8'h49;
    if (!row && col == 4'd14) st_ch = 8'h4E;
    if (row && col == 4'd12) st_ch = 8'h4F;
    if (row && col == 4'd13) st_ch = 8'h55;
    if (row && col == 4'd14) st_ch = 8'h54;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (!row && col == 4'(1 + 2 * i)) st_ch = digit(shifts[5*i +: 5], 1'b1);
      if (!row && col == 4'(2 + 2 * i)) st_ch = digit(shifts[5*i +: 5], 1'b0);
      if (row && col == 4'(1 + i)) st_ch = 8'h31 + 8'(types[3*i +: 3]);
    end
  end
  // age 0 is the newest entry, stored just below the write pointer
  always_comb begin
    age = scr_q + (HPTR_W+1)'(4'd15 - col);
    idx = wp_q + ~age[HPTR_W-1:0];
    ent = mem_q[idx];
    hi_ch = age < cnt_q ? letter(row ? ent[4:0] : ent[9:5]) : 8'h20;
    dout_d = disp_or_hist ? hi_ch : st_ch;
    wr = key_valid && !hist_clear;
    smax = cnt_q > VIEW ? cnt_q - VIEW : '0;
    wp_d = hist_clear ? '0 : wr ? wp_q + 1'b1 : wp_q;
    cnt_d = hist_clear ? '0 : wr ? (cnt_q == DEPTH ? cnt_q : cnt_q + 1'b1) : cnt_q;
    scr_d = (hist_clear || key_valid) ? '0 :
            (scroll_up && !scroll_down) ? (scr_q + 1'b1 > smax ? smax : scr_q + 1'b1) :
            (scroll_down && !scroll_up) ? (scr_q == '0 ? scr_q : scr_q - 1'b1) : scr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= 8'h20;
      wp_q <= '0;
      cnt_q <= '0;
      scr_q <= '0;
    end else begin
      dout_q <= dout_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      scr_q <= scr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= {befor, after};
  end
  assign dout = dout_q;
  assign hist_count = cnt_q;
  assign scroll = scr_q;
endmodule

// File: tb/tb_enigma_lcd_screen_builder.sv
// tb_enigma_lcd_screen_builder: directed checks of status screen, history ring and scrolling
module tb_enigma_lcd_screen_builder;
  logic clk = 0, rst_n, disp_or_hist, key_valid, hist_clear, scroll_up, scroll_down;
  logic [4:0] befor, after, raddr;
  logic [14:0] shifts;
  logic [8:0] types;
  logic [7:0] dout;
  logic [5:0] hist_count, scroll;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  enigma_lcd_screen_builder dut (
    .clk(clk), .rst_n(rst_n), .disp_or_hist(disp_or_hist), .key_valid(key_valid),
    .befor(befor), .after(after), .shifts(shifts), .types(types),
    .hist_clear(hist_clear), .scroll_up(scroll_up), .scroll_down(scroll_down),
    .raddr(raddr), .dout(dout), .hist_count(hist_count), .scroll(scroll)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] e);
    raddr = a;
    tick;
    chk(tag, dout, e);
  endtask
  task automatic key(input logic [4:0] b, input logic [4:0] a);
    key_valid = 1; befor = b; after = a;
    tick;
    key_valid = 0;
  endtask
  task automatic up(input int n);
    for (int i = 0; i < n; i++) begin
      scroll_up = 1;
      tick;
      scroll_up = 0;
    end
  endtask
  task automatic clr;
    hist_clear = 1;
    tick;
    hist_clear = 0;
  endtask
  initial begin
    rst_n = 0; disp_or_hist = 0; key_valid = 0; hist_clear = 0; scroll_up = 0; scroll_down = 0;
    befor = 0; after = 0; raddr = 0; shifts = '0; types = '0;
    tick; tick;
    chk("rst_dout", dout, 8'h20);
    chk("rst_cnt", hist_count, 0);
    chk("rst_scroll", scroll, 0);
    rst_n = 1;
    shifts = {5'd25, 5'd10, 5'd7}; types = {3'd7, 3'd3, 3'd0}; befor = 2; after = 24;
    rd("st_S", 5'h00, "S");
    rd("st_01", 5'h01, "0"); rd("st_02", 5'h02, "7");
    rd("st_03", 5'h03, "1"); rd("st_04", 5'h04, "0");
    rd("st_05", 5'h05, "2"); rd("st_06", 5'h06, "5");
    rd("st_07", 5'h07, 8'h20);
    rd("st_0D", 5'h0D, "I"); rd("st_0E", 5'h0E, "N"); rd("st_0F", 5'h0F, "C");
    rd("st_T", 5'h10, "T");
    rd("st_11", 5'h11, "1"); rd("st_12", 5'h12, "4"); rd("st_13", 5'h13, "8");
    rd("st_14", 5'h14, 8'h20);
    rd("st_1C", 5'h1C, "O"); rd("st_1D", 5'h1D, "U"); rd("st_1F", 5'h1F, "Y");
    shifts = {5'd25, 5'd30, 5'd7}; befor = 27;
    rd("st_bad_sh", 5'h03, "?");
    rd("st_bad_sh2", 5'h04, "?");
    rd("st_bad_in", 5'h0F, "?");
    disp_or_hist = 1;
    key(0, 16); key(1, 17); key(2, 18);
    chk("h3_cnt", hist_count, 3);
    rd("h3_0F", 5'h0F, "C");
    raddr = 5'h0E;
    #1 chk("h3_latency", dout, "C");
    tick;
    chk("h3_0E", dout, "B");
    rd("h3_0D", 5'h0D, "A"); rd("h3_0C", 5'h0C, 8'h20); rd("h3_1F", 5'h1F, "S");
    rd("h3_1D", 5'h1D, "Q");
    raddr = 5'h0F;
    key(3, 19);
    chk("h3_pre_write", dout, "C");
    rd("h3_post_write", 5'h0F, "D");
    clr;
    for (int k = 0; k < 40; k++) key(5'(k % 26), 5'((k + 1) % 26));
    chk("h40_cnt", hist_count, 32);
    rd("h40_0F", 5'h0F, "N");
    up(20);
    chk("h40_scroll", scroll, 16);
    rd("h40_col0", 5'h00, "I");
    rd("h40_col0_r1", 5'h10, "J");
    scroll_down = 1; tick; scroll_down = 0;
    chk("h40_down", scroll, 15);
    rd("h40_col0_dn", 5'h00, "J");
    scroll_up = 1; scroll_down = 1; tick; scroll_up = 0; scroll_down = 0;
    chk("h40_both", scroll, 15);
    scroll_up = 1; key(5, 6); scroll_up = 0;
    chk("kv_up_scroll", scroll, 0);
    chk("kv_up_cnt", hist_count, 32);
    rd("kv_up_0F", 5'h0F, "F");
    hist_clear = 1; key(7, 8); hist_clear = 0;
    chk("clr_kv_cnt", hist_count, 0);
    rd("clr_kv_0F", 5'h0F, 8'h20);
    rd("clr_kv_1F", 5'h1F, 8'h20);
    for (int k = 0; k < 3; k++) key(5'(k), 5'(k));
    up(1);
    chk("small_scroll", scroll, 0);
    clr;
    for (int k = 0; k < 20; k++) key(5'(k), 5'(k));
    up(9);
    chk("h20_smax", scroll, 4);
    disp_or_hist = 0; raddr = 5'h00; rst_n = 0;
    tick;
    rst_n = 1;
    chk("mid_rst_cnt", hist_count, 0);
    chk("mid_rst_scroll", scroll, 0);
    chk("mid_rst_dout", dout, 8'h20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
